shift_right_serializer_ctrl: RTL and testbench

SHIFT_RIGHT_SERIALIZER_CTRL -- requirements
Module: shift_right_serializer_ctrl

---
 rtl/shift_right_serializer_ctrl.sv | 101 ++++++++++
 tb/tb_shift_right_serializer_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/shift_right_serializer_ctrl.sv
// LSB-first serializer: loads a word, shifts it out one bit per
// unstalled cycle, then pulses done with the word's popcount.
module shift_right_serializer_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             stall,
  output logic             busy,
  output logic             bit_valid,
  output logic             bit_out,
  output logic [CNT_W-1:0] bit_idx,
  output logic             done,
  output logic [CNT_W-1:0] ones
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0] acc_nx;

  assign acc_nx = acc_q + {{(CNT_W-1){1'b0}}, shreg_q[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ones_q  <= ones_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ones_d    = ones_q;
    busy      = 1'b0;
    bit_valid = 1'b0;
    bit_out   = 1'b0;
    bit_idx   = '0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = din;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy      = 1'b1;
        bit_valid = !stall;
        bit_out   = shreg_q[0];
        bit_idx   = cnt_q;
        if (!stall) begin
          shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          acc_d   = acc_nx;
          // Final bit: latch the full count so it survives into IDLE
          if (cnt_q == LAST) begin
            ones_d  = acc_nx;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ones = ones_q;

endmodule

// File: tb/tb_shift_right_serializer_ctrl.sv
// Bench for shift_right_serializer_ctrl: vector table, directed
// corner sequences and random traffic against a queue-based model.
module tb_shift_right_serializer_ctrl;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, start, stall;
  logic [W-1:0]  din;
  logic          busy, bit_valid, bit_out, done;
  logic [CW-1:0] bit_idx, ones;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_right_serializer_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .din      (din),
    .stall    (stall),
    .busy     (busy),
    .bit_valid(bit_valid),
    .bit_out  (bit_out),
    .bit_idx  (bit_idx),
    .done     (done),
    .ones     (ones)
  );

  // model: 0 idle, 1 emitting bits, 2 reporting
  int         m_mode;
  bit         m_q[$];
  int         m_idx;
  logic [W-1:0] m_word;
  int         m_last;

  logic          o_busy, o_valid, o_bo, o_done;
  logic [CW-1:0] o_idx, o_ones;
  int            done_cnt;
  int            valid_cnt;

  typedef struct {
    logic          s, st, r;
    logic [W-1:0]  d;
    logic          busy, valid, bo;
    logic [CW-1:0] idx;
    logic          done;
    logic [CW-1:0] ones;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", n, got, exp, $time);
    end
  endtask

  task automatic step(input logic s, input logic st, input logic r,
                      input logic [W-1:0] d);
    start = s; stall = st; rst = r; din = d;
    @(negedge clk);
    o_busy = busy; o_valid = bit_valid; o_bo = bit_out;
    o_idx = bit_idx; o_done = done; o_ones = ones;
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("bit_valid", 32'(bit_valid), 32'(m_mode == 1 && !st));
    chk("bit_out", 32'(bit_out), (m_mode == 1) ? 32'(m_q[0]) : 0);
    chk("bit_idx", 32'(bit_idx), (m_mode == 1) ? m_idx : 0);
    chk("done", 32'(done), 32'(m_mode == 2));
    chk("ones", 32'(ones), m_last);
    if (done) done_cnt++;
    if (bit_valid) valid_cnt++;
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_q.delete(); m_idx = 0; m_last = 0;
    end else begin
      case (m_mode)
        0: if (s) begin
          m_q.delete();
          for (int i = 0; i < W; i++) m_q.push_back(d[i]);
          m_word = d; m_idx = 0; m_mode = 1;
        end
        1: if (!st) begin
          void'(m_q.pop_front());
          m_idx++;
          if (m_q.size() == 0) begin
            m_mode = 2;
            m_last = $countones(m_word);
          end
        end
        default: m_mode = 0;
      endcase
    end
    #1;
  endtask

  function automatic vec_t mk(logic s, logic [W-1:0] d, logic b,
      logic v, logic bo, int idx, logic dn, int on);
    vec_t x;
    x.s = s; x.st = 1'b0; x.r = 1'b0; x.d = d;
    x.busy = b; x.valid = v; x.bo = bo;
    x.idx = CW'(idx); x.done = dn; x.ones = CW'(on);
    return x;
  endfunction

  initial begin
    logic [W-1:0] pat;
    int hits, hit_idx, done_cyc, idx5, busy6;
    pat = 8'b10110010;
    tbl[0] = mk(1, pat, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++)
      tbl[i] = mk(0, 0, 1, 1, pat[i-1], i - 1, 0, 0);
    tbl[9]  = mk(0, 0, 1, 0, 0, 0, 1, 4);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 4);

    rst = 1'b1; start = 1'b0; stall = 1'b0; din = '0;
    m_mode = 0; m_idx = 0; m_last = 0; m_word = '0;
    done_cnt = 0; valid_cnt = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset state, then the 10110010 word
    step(0, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].s, tbl[i].st, tbl[i].r, tbl[i].d);
      chk("tbl_busy", 32'(o_busy), 32'(tbl[i].busy));
      chk("tbl_valid", 32'(o_valid), 32'(tbl[i].valid));
      chk("tbl_bit", 32'(o_bo), 32'(tbl[i].bo));
      chk("tbl_idx", 32'(o_idx), 32'(tbl[i].idx));
      chk("tbl_done", 32'(o_done), 32'(tbl[i].done));
      chk("tbl_ones", 32'(o_ones), 32'(tbl[i].ones));
    end

    // one-hot words
    for (int k = 0; k < W; k++) begin
      pat = '0; pat[k] = 1'b1;
      hits = 0; hit_idx = -1;
      for (int c = 0; c < 11; c++) begin
        step(c == 0, 0, 0, pat);
        if (o_valid && o_bo) begin hits++; hit_idx = int'(o_idx); end
      end
      chk("onehot_hits", hits, 1);
      chk("onehot_idx", hit_idx, k);
      chk("onehot_ones", 32'(ones), 1);
    end

    // FF with two stall cycles
    done_cyc = -1; idx5 = -1; done_cnt = 0;
    for (int c = 0; c < 13; c++) begin
      step(c == 0, (c == 3 || c == 4), 0, 8'hFF);
      if (o_done) done_cyc = c;
      if (c == 5) idx5 = int'(o_idx);
    end
    chk("stall_done_cyc", done_cyc, 11);
    chk("stall_idx_repeat", idx5, 2);
    chk("stall_ones", 32'(ones), 8);

    // extra starts mid-word are ignored
    done_cnt = 0;
    for (int c = 0; c < 12; c++)
      step(c == 0 || c == 4 || c == 9, 0, 0, (c == 0) ? 8'hA5 : 8'hFF);
    chk("ign_done_cnt", done_cnt, 1);
    chk("ign_ones", 32'(ones), 4);

    // reset mid-word aborts silently
    done_cnt = 0; busy6 = -1;
    for (int c = 0; c < 12; c++) begin
      step(c == 0, 0, c == 5, 8'hC3);
      if (c == 6) busy6 = int'(o_busy) + int'(o_valid);
    end
    chk("abort_done_cnt", done_cnt, 0);
    chk("abort_idle", busy6, 0);
    done_cnt = 0;
    for (int c = 0; c < 11; c++) step(c == 0, 0, 0, 8'h3C);
    chk("post_rst_done", done_cnt, 1);
    chk("post_rst_ones", 32'(ones), 4);

    // back-to-back zero words
    done_cnt = 0; valid_cnt = 0;
    for (int c = 0; c < 21; c++) step(c == 0 || c == 10, 0, 0, 8'h00);
    chk("b2b_done_cnt", done_cnt, 2);
    chk("b2b_valid_cnt", valid_cnt, 16);
    chk("b2b_ones", 32'(ones), 0);

    // random traffic
    for (int c = 0; c < 3000; c++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 63) == 0, W'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
